ecp5pll_phase_stepper: RTL and testbench

Sequencer driving the dynamic phase-shift port of the ECP5 PLL wrapper (`phasesel`, `phasedir`, `phasestep`, `phaseloadreg`, `locked`). It accepts "shift output N by K steps, direction D" requests over a valid/ready handshake and generates correctly timed select, direction and step pulses. It also tracks the accumulated phase position of each PLL output modulo one full turn. It sits between system logic (e.g. SDRAM/video clock alignment) and the PLL instance.

---
 rtl/ecp5pll_phase_stepper.sv | 134 +++++++++++++
 tb/tb_ecp5pll_phase_stepper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ecp5pll_phase_stepper.sv
// ecp5pll_phase_stepper: sequences ECP5 PLL dynamic phase-shift steps
// (select/direction setup, step pulse, gap) and tracks each output's
// phase position modulo one full turn.
module ecp5pll_phase_stepper #(
  parameter int setup_cyc  = 2,
  parameter int pulse_cyc  = 2,
  parameter int gap_cyc    = 4,
  parameter int out0_steps = 8,
  parameter int out1_steps = 8,
  parameter int out2_steps = 8,
  parameter int out3_steps = 8
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_count,
  output logic        done,
  output logic        busy,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg,
  input  logic        locked,
  output logic [39:0] phase_pos
);
  localparam int NUM_LANES = 4;
  localparam int POS_W     = 10;

  function automatic int lane_steps(input int n);
    case (n)
      0:       return out0_steps;
      1:       return out1_steps;
      2:       return out2_steps;
      default: return out3_steps;
    endcase
  endfunction

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} st_t;

  st_t        st, st_nx;
  logic [7:0] cnt, rem;
  logic [1:0] lk;
  logic       lock_s;
  logic       acc, step_last;
  logic       ready_d, busy_d, done_d, step_d;
  logic [NUM_LANES-1:0][POS_W-1:0] pos;

  assign lock_s       = lk[1];
  assign acc          = req_valid && req_ready;
  assign step_last    = (st == PULSE) && (cnt == 8'(pulse_cyc - 1));
  assign phaseloadreg = 1'b0;
  assign phase_pos    = pos;

  // two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk_i or posedge reset)
    if (reset) lk <= '0;
    else       lk <= {lk[0], locked};

  // state register
  always_ff @(posedge clk_i or posedge reset)
    if (reset) st <= IDLE;
    else       st <= st_nx;

  // next-state logic; SETUP never releases a step while unlocked
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:  if (acc) st_nx = (req_count == 8'd0) ? DONE : SETUP;
      SETUP: if (lock_s && cnt == 8'(setup_cyc - 1)) st_nx = PULSE;
      PULSE: if (step_last) st_nx = GAP;
      GAP:   if (cnt == 8'(gap_cyc - 1)) st_nx = (rem == 8'd0) ? DONE : SETUP;
      DONE:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // output decode from next state so every output comes straight off a flop
  always_comb begin
    ready_d = (st_nx == IDLE);
    busy_d  = (st_nx != IDLE);
    done_d  = (st_nx == DONE);
    step_d  = (st_nx == PULSE);
  end

  // registered handshake/status/step outputs
  always_ff @(posedge clk_i or posedge reset)
    if (reset) begin
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phasestep <= 1'b0;
    end else begin
      req_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      phasestep <= step_d;
    end

  // in-state cycle counter; setup restarts while unlocked so select/dir
  // always see a full setup window of locked time before the pulse
  always_ff @(posedge clk_i or posedge reset)
    if (reset) cnt <= '0;
    else if (st_nx != st || st == IDLE || (st == SETUP && !lock_s)) cnt <= '0;
    else cnt <= cnt + 8'd1;

  // request latch: select/dir held for the whole request, remaining steps
  always_ff @(posedge clk_i or posedge reset)
    if (reset) begin
      phasesel <= '0;
      phasedir <= 1'b0;
      rem      <= '0;
    end else if (acc) begin
      phasesel <= req_sel;
      phasedir <= req_dir;
      rem      <= req_count;
    end else if (step_last) begin
      rem      <= rem - 8'd1;
    end

  // per-output phase position, modulo that output's steps per turn
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [POS_W-1:0] LAST = POS_W'(lane_steps(g) - 1);
    always_ff @(posedge clk_i or posedge reset)
      if (reset) pos[g] <= '0;
      else if (step_last && phasesel == 2'(g)) begin
        if (phasedir) pos[g] <= (pos[g] == '0)  ? LAST : pos[g] - 10'd1;
        else          pos[g] <= (pos[g] == LAST) ? '0  : pos[g] + 10'd1;
      end
  end

endmodule

// File: tb/tb_ecp5pll_phase_stepper.sv
// Directed bench for ecp5pll_phase_stepper (defaults, out2_steps = 16).
module tb_ecp5pll_phase_stepper;
  logic        clk_i = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        req_dir;
  logic [7:0]  req_count;
  logic        done, busy;
  logic [1:0]  phasesel;
  logic        phasedir, phasestep, phaseloadreg;
  logic        locked;
  logic [39:0] phase_pos;

  int total  = 0;
  int passed = 0;
  int dcyc;
  bit seen;

  ecp5pll_phase_stepper #(.out2_steps(16)) dut (
    .clk_i(clk_i), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_count(req_count),
    .done(done), .busy(busy),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .locked(locked), .phase_pos(phase_pos)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // issue one request (caller ensures req_ready), return cycle of done
  task automatic run_req(input logic [1:0] s, input logic d, input logic [7:0] n,
                         output int dc);
    dc = -1;
    req_valid = 1'b1; req_sel = s; req_dir = d; req_count = n;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (i == 1) req_valid = 1'b0;
      if (done === 1'b1) begin dc = i; break; end
    end
    step();
  endtask

  initial begin
    reset = 1'b1; locked = 1'b1; req_valid = 1'b0;
    req_sel = '0; req_dir = 1'b0; req_count = '0;
    step(); step();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", phasestep, 0);
    chk("rst_sel", phasesel, 0);
    chk("rst_dir", phasedir, 0);
    chk("rst_load", phaseloadreg, 0);
    chk("rst_pos", phase_pos, 0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", req_ready, 1);
    step(); step(); step();

    // three lag steps on output 1
    req_valid = 1'b1; req_sel = 2'd1; req_dir = 1'b0; req_count = 8'd3;
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c == 1) req_valid = 1'b0;
      chk($sformatf("t1_step_c%0d", c), phasestep,
          (c == 3 || c == 4 || c == 11 || c == 12 || c == 19 || c == 20));
      chk($sformatf("t1_done_c%0d", c), done, (c == 25));
      chk($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 25));
      if (c == 1 || c == 20) begin
        chk("t1_sel", phasesel, 1);
        chk("t1_dir", phasedir, 0);
      end
      if (c == 5) chk("t1_pos_c5", phase_pos[19:10], 1);
    end
    chk("t1_pos_end", phase_pos[19:10], 3);
    chk("t1_ready_end", req_ready, 1);

    // output 2 (16 steps): lead underflow wrap, then lag overflow wrap
    run_req(2'd2, 1'b1, 8'd1, dcyc);
    chk("t2_done_cyc_a", dcyc, 9);
    chk("t2_pos_a", phase_pos[29:20], 15);
    chk("t2_pos1_kept", phase_pos[19:10], 3);
    run_req(2'd2, 1'b0, 8'd2, dcyc);
    chk("t2_done_cyc_b", dcyc, 17);
    chk("t2_pos_b", phase_pos[29:20], 1);

    // count=0, with req_valid held into a second request on output 0
    req_valid = 1'b1; req_sel = 2'd0; req_dir = 1'b0; req_count = 8'd0;
    step();
    chk("t4_done_c1", done, 1);
    chk("t4_step_c1", phasestep, 0);
    chk("t4_ready_c1", req_ready, 0);
    chk("t4_pos_c1", phase_pos[9:0], 0);
    req_dir = 1'b1; req_count = 8'd1;
    step();
    chk("t4_ready_c2", req_ready, 1);
    chk("t4_done_c2", done, 0);
    chk("t4_step_c2", phasestep, 0);
    for (int c = 3; c <= 12; c++) begin
      step();
      if (c == 3) req_valid = 1'b0;
      chk($sformatf("t4_step_c%0d", c), phasestep, (c == 5 || c == 6));
      chk($sformatf("t4_done_c%0d", c), done, (c == 11));
    end
    chk("t4_pos0_wrap", phase_pos[9:0], 7);
    chk("t4_ready_end", req_ready, 1);

    // lock low: request stalls in setup until the lock returns
    locked = 1'b0;
    step(); step(); step();
    req_valid = 1'b1; req_sel = 2'd3; req_dir = 1'b0; req_count = 8'd1;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) req_valid = 1'b0;
      if (phasestep !== 1'b0) seen = 1'b1;
    end
    chk("t3_no_step_unlocked", seen, 0);
    chk("t3_busy_unlocked", busy, 1);
    locked = 1'b1;
    step(); step(); step();
    chk("t3_step_before", phasestep, 0);
    step();
    chk("t3_step_start", phasestep, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    chk("t3_done_seen", seen, 1);
    step();
    chk("t3_pos3", phase_pos[39:30], 1);
    chk("t3_all_pos", phase_pos, {10'd1, 10'd1, 10'd3, 10'd7});
    chk("t3_ready", req_ready, 1);

    // reset during the second of five pulses
    req_valid = 1'b1; req_sel = 2'd1; req_dir = 1'b0; req_count = 8'd5;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) req_valid = 1'b0;
    end
    chk("t5_step_2nd", phasestep, 1);
    chk("t5_pos_mid", phase_pos[19:10], 4);
    reset = 1'b1;
    #1;
    chk("t5_rst_step", phasestep, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_sel", phasesel, 0);
    chk("t5_rst_pos", phase_pos, 0);
    step(); step();
    reset = 1'b0;
    step(); step(); step(); step();
    chk("t5_ready_after", req_ready, 1);
    run_req(2'd1, 1'b0, 8'd1, dcyc);
    chk("t5_done_cyc", dcyc, 9);
    chk("t5_pos_after", phase_pos, 40'h00_0000_0400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
